// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the arbiter state encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request searching upward from last_i+1, wrapping.
module rr_picker #(
    parameter int REQUESTERS = 4,
    parameter int IDX_W      = $clog2(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] req_i,
    input  logic [IDX_W-1:0]      last_i,
    output logic                  any_o,
    output logic [IDX_W-1:0]      winner_o
);

    always_comb begin
        logic found;
        int   idx;
        // NOTE: every output and local gets a default first so no path leaves a value held, which would infer a latch.
        any_o    = |req_i;
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        // Offsets 1..REQUESTERS visit last_i+1 first and last_i itself last.
        for (int i = 1; i <= REQUESTERS; i++) begin
            idx = (int'(last_i) + i) % REQUESTERS;
            if (!found && req_i[idx]) begin
                winner_o = idx[IDX_W-1:0];
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UartTx among REQUESTERS byte sources.
// Define UART_TX_ARB_WATCHDOG_EN to add the SEND-state watchdog that drives Timeout_o.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int REQUESTERS    = 4,
    parameter int GAP_TICKS     = 0,
    parameter int TIMEOUT_TICKS = 2000
) (
    input  logic                              Clock,
    input  logic                              Reset,
    input  logic [REQUESTERS-1:0]             Request_i,
    input  logic [UART_DATA_W*REQUESTERS-1:0] Data_i,
    output logic [REQUESTERS-1:0]             Ack_o,
    output logic [REQUESTERS-1:0]             Done_o,
    output logic                              Timeout_o,
    output logic                              Busy_o,
    output logic                              TxStart_o,
    output logic [UART_DATA_W-1:0]            TxData_o,
    input  logic                              TxDone_i
);

    localparam int IDX_W = $clog2(REQUESTERS);
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam arb_state_e POST_FRAME_ST = (GAP_TICKS > 0) ? ST_GAP : ST_IDLE;

    if (REQUESTERS < 2 || REQUESTERS > 16 || GAP_TICKS < 0 || TIMEOUT_TICKS < 1) begin : g_param_check
        $error("uart_tx_arbiter: parameter out of range");
    end

    arb_state_e                 state_q, state_d;
    logic [IDX_W-1:0]           last_q, last_d;
    logic [IDX_W-1:0]           grant_q, grant_d;
    logic [UART_DATA_W-1:0]     tx_data_q, tx_data_d;
    logic                       tx_start_q, tx_start_d;
    logic [REQUESTERS-1:0]      ack_q, ack_d;
    logic [REQUESTERS-1:0]      done_q, done_d;
    logic [GAP_W-1:0]           gap_cnt_q, gap_cnt_d;
    logic                       pick_any;
    logic [IDX_W-1:0]           pick_winner;

`ifdef UART_TX_ARB_WATCHDOG_EN
    localparam int WDOG_W = $clog2(TIMEOUT_TICKS + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_q, timeout_d;
`endif

    rr_picker #(
        .REQUESTERS (REQUESTERS),
        .IDX_W      (IDX_W)
    ) u_picker (
        .req_i    (Request_i),
        .last_i   (last_q),
        .any_o    (pick_any),
        .winner_o (pick_winner)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        ack_d      = '0;
        done_d     = '0;
        gap_cnt_d  = gap_cnt_q;
`ifdef UART_TX_ARB_WATCHDOG_EN
        wdog_d     = wdog_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d             = pick_winner;
                    tx_data_d           = Data_i[UART_DATA_W*int'(pick_winner) +: UART_DATA_W];
                    tx_start_d          = 1'b1;
                    ack_d[pick_winner]  = 1'b1;
                    state_d             = ST_SEND;
`ifdef UART_TX_ARB_WATCHDOG_EN
                    wdog_d              = '0;
`endif
                end
            end
            ST_SEND: begin
                // A completion arriving on the expiry cycle takes priority over the watchdog.
                if (TxDone_i) begin
                    done_d[grant_q] = 1'b1;
                    last_d          = grant_q;
                    gap_cnt_d       = '0;
                    state_d         = POST_FRAME_ST;
                end
`ifdef UART_TX_ARB_WATCHDOG_EN
                else if (wdog_q == WDOG_W'(TIMEOUT_TICKS - 1)) begin
                    timeout_d = 1'b1;
                    last_d    = grant_q;
                    gap_cnt_d = '0;
                    state_d   = POST_FRAME_ST;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_TICKS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            last_q     <= IDX_W'(REQUESTERS - 1);
            grant_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            ack_q      <= '0;
            done_q     <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

`ifdef UART_TX_ARB_WATCHDOG_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign Timeout_o = timeout_q;
`else
    assign Timeout_o = 1'b0;
`endif

    assign Ack_o     = ack_q;
    assign Done_o    = done_q;
    assign Busy_o    = (state_q != ST_IDLE);
    assign TxStart_o = tx_start_q;
    assign TxData_o  = tx_data_q;

endmodule
